// File: rtl/mips_issue_arbiter.sv
// Round-robin front end sharing one MIPS core between two requester FIFOs; one instruction in flight.
// Grant-to-rsp_valid is 2 + core latency; requesters stall on FIFO full, responses hold until rsp_ready.

module mips_issue_fifo #(
   parameter int W     = 52,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_pop,
   output logic [W-1:0] out_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   // Ready comes only from the registered count, so a full FIFO refuses a push even while popping.
   assign in_rdy  = rst_n & (count < FULL);
   assign out_vld = (count != '0);
   assign out_dat = mem[rd_ptr];
   assign push    = in_vld & in_rdy;
   assign pop     = out_pop & out_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_dat;
   end
endmodule

module mips_issue_arbiter #(
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_instr,
   input  logic [19:0] req0_oreg,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_instr,
   input  logic [19:0] req1_oreg,
   output logic        core_in_valid,
   output logic [31:0] core_instruction,
   output logic [19:0] core_output_reg,
   input  logic        core_out_valid,
   input  logic        core_fail,
   input  logic [63:0] core_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic        rsp_fail,
   output logic        rsp_timeout,
   output logic [63:0] rsp_data,
   output logic        busy
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          rr_last;
   logic          issue_id;
   logic          late_pending;

   logic          ne0, ne1;
   logic [51:0]   head0, head1;
   logic          grant_any;
   logic          grant_id;
   logic [51:0]   grant_dat;

   mips_issue_fifo #(.W(52), .DEPTH(DEPTH)) u_fifo0 (
      .clk(clk), .rst_n(rst_n),
      .in_vld(req0_valid), .in_rdy(req0_ready), .in_dat({req0_instr, req0_oreg}),
      .out_vld(ne0), .out_pop(grant_any & ~grant_id), .out_dat(head0)
   );

   mips_issue_fifo #(.W(52), .DEPTH(DEPTH)) u_fifo1 (
      .clk(clk), .rst_n(rst_n),
      .in_vld(req1_valid), .in_rdy(req1_ready), .in_dat({req1_instr, req1_oreg}),
      .out_vld(ne1), .out_pop(grant_any & grant_id), .out_dat(head1)
   );

   // With both queues occupied the requester that did not win last time goes next.
   assign grant_any = (state == S_IDLE) & (ne0 | ne1);
   assign grant_id  = (ne0 & ne1) ? ~rr_last : ne1;
   assign grant_dat = grant_id ? head1 : head0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         wait_cnt         <= '0;
         rr_last          <= 1'b0;
         issue_id         <= 1'b0;
         late_pending     <= 1'b0;
         core_in_valid    <= 1'b0;
         core_instruction <= '0;
         core_output_reg  <= '0;
         rsp_valid        <= 1'b0;
         rsp_id           <= 1'b0;
         rsp_fail         <= 1'b0;
         rsp_timeout      <= 1'b0;
         rsp_data         <= '0;
         busy             <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  core_in_valid    <= 1'b1;
                  core_instruction <= grant_dat[51:20];
                  core_output_reg  <= grant_dat[19:0];
                  issue_id         <= grant_id;
                  rr_last          <= grant_id;
                  busy             <= 1'b1;
                  state            <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               core_in_valid    <= 1'b0;
               core_instruction <= '0;
               core_output_reg  <= '0;
               wait_cnt         <= '0;
               state            <= S_WAIT;
            end
            S_WAIT: begin
               // A completion in the same cycle as the deadline still counts as a real result.
               if (core_out_valid) begin
                  rsp_valid   <= 1'b1;
                  rsp_id      <= issue_id;
                  rsp_fail    <= core_fail;
                  rsp_timeout <= 1'b0;
                  rsp_data    <= core_fail ? 64'd0 : core_out;
                  state       <= S_RESP;
               end else if (wait_cnt == CNT_LAST) begin
                  rsp_valid    <= 1'b1;
                  rsp_id       <= issue_id;
                  rsp_fail     <= 1'b1;
                  rsp_timeout  <= 1'b1;
                  rsp_data     <= '0;
                  late_pending <= 1'b1;
                  state        <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (late_pending && core_out_valid) late_pending <= 1'b0;
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  rsp_id      <= 1'b0;
                  rsp_fail    <= 1'b0;
                  rsp_timeout <= 1'b0;
                  rsp_data    <= '0;
                  if (late_pending && !core_out_valid) begin
                     state <= S_DRAIN;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
            end
            S_DRAIN: begin
               // The timed-out instruction must leave the core before anything else is issued.
               if (core_out_valid) begin
                  late_pending <= 1'b0;
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
